display_scan_ctrl: RTL and testbench

Time-multiplexing controller that drives one display_digit instance for a 4-digit 7-segment display. It holds a 4-nibble display value and per-digit decimal points, steps the digit select at a programmable refresh rate, and presents the matching digit_val/dp. New values are double-buffered and committed only at a scan-frame boundary, so a digit never shows a torn update. Optional leading-zero blanking is reported on a blank output, which downstream logic uses to gate the anode.

---
 rtl/display_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : display_scan_ctrl                                                |
// | Purpose : Time-multiplexed scan controller for a 4-digit 7-segment display.|
// |           Holds a double-buffered 4-nibble value with per-digit decimal    |
// |           points, steps the digit select at REFRESH_DIV clocks per slot,   |
// |           and presents registered digit_val/dp/blank for the selected      |
// |           digit. Pending values commit only at a frame boundary.           |
// | Options : define BLINK_EN to add blink_mask[3:0] and a per-digit blink     |
// |           phase that toggles every BLINK_FRAMES frames.                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
`ifdef BLINK_EN
  , parameter int BLINK_FRAMES = 128
`endif
) (
  input  logic        src_clk,
  input  logic        src_rst,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
`ifdef BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  output logic        busy,
  output logic [1:0]  select,
  output logic [3:0]  digit_val,
  output logic        dp,
  output logic        blank,
  output logic        frame_done
);

  localparam int c_PRESC_W = $clog2(REFRESH_DIV);

  logic [c_PRESC_W-1:0] r_presc;
  logic [1:0]           r_sel;
  logic [15:0]          r_act_val;
  logic [3:0]           r_act_dp;
  logic [15:0]          r_sh_val;
  logic [3:0]           r_sh_dp;
  logic                 r_busy;
  logic [3:0]           r_digit;
  logic                 r_dp;
  logic                 r_blank;
  logic                 r_frame_done;

  logic                 w_tick;
  logic                 w_boundary;
  logic [1:0]           w_sel_next;
  logic [15:0]          w_nxt_val;
  logic [3:0]           w_nxt_dp;
  logic [3:0]           w_lz;
  logic [3:0]           w_digit;
  logic                 w_blank;
  logic                 w_dp;

`ifdef BLINK_EN
  localparam int c_FC_W = $clog2(BLINK_FRAMES + 1);
  logic [c_FC_W-1:0]    r_fcnt;
  logic                 r_phase;
`endif

  assign w_tick     = (r_presc == c_PRESC_W'(REFRESH_DIV - 1));
  assign w_boundary = w_tick && (r_sel == 2'd3);
  assign w_sel_next = r_sel + 2'd1;

  // Active value as it will be after this edge; the first slot of a new frame
  // must already show freshly committed data.
  always_comb begin
    w_nxt_val = r_act_val;
    w_nxt_dp  = r_act_dp;
    if (w_boundary) begin
      if (load) begin
        w_nxt_val = value_in;
        w_nxt_dp  = dp_in;
      end else if (r_busy) begin
        w_nxt_val = r_sh_val;
        w_nxt_dp  = r_sh_dp;
      end
    end
  end

  // Leading-zero chain from the top digit down; a lit dp breaks the chain so
  // that digit and every lower digit stay visible. Digit 0 is never blanked.
  always_comb begin
    w_lz    = 4'b0000;
    w_lz[3] = (w_nxt_val[15:12] == 4'd0) && !w_nxt_dp[3];
    w_lz[2] = w_lz[3] && (w_nxt_val[11:8] == 4'd0) && !w_nxt_dp[2];
    w_lz[1] = w_lz[2] && (w_nxt_val[7:4] == 4'd0) && !w_nxt_dp[1];
    w_lz[0] = 1'b0;
    w_digit = w_nxt_val[{w_sel_next, 2'b00} +: 4];
    w_blank = blank_lz && w_lz[w_sel_next];
`ifdef BLINK_EN
    if (r_phase && blink_mask[w_sel_next]) begin
      w_blank = 1'b1;
    end
`endif
    w_dp = w_nxt_dp[w_sel_next] && !w_blank;
  end

  // Slot prescaler and digit select.
  always_ff @(posedge src_clk) begin
    if (!src_rst) begin
      r_presc <= '0;
      r_sel   <= 2'd0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_sel   <= w_sel_next;
    end else begin
      r_presc <= r_presc + c_PRESC_W'(1);
    end
  end

  // Shadow/active double buffer; a load on the boundary edge bypasses the shadow.
  always_ff @(posedge src_clk) begin
    if (!src_rst) begin
      r_act_val <= 16'd0;
      r_act_dp  <= 4'd0;
      r_sh_val  <= 16'd0;
      r_sh_dp   <= 4'd0;
      r_busy    <= 1'b0;
    end else begin
      r_act_val <= w_nxt_val;
      r_act_dp  <= w_nxt_dp;
      if (w_boundary) begin
        r_busy <= 1'b0;
      end else if (load) begin
        r_sh_val <= value_in;
        r_sh_dp  <= dp_in;
        r_busy   <= 1'b1;
      end
    end
  end

  // Registered display outputs, all updated on the same tick edge.
  always_ff @(posedge src_clk) begin
    if (!src_rst) begin
      r_digit      <= 4'd0;
      r_dp         <= 1'b0;
      r_blank      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_tick) begin
        r_digit <= w_digit;
        r_dp    <= w_dp;
        r_blank <= w_blank;
      end
    end
  end

`ifdef BLINK_EN
  // Blink phase flips after every BLINK_FRAMES frame_done pulses.
  always_ff @(posedge src_clk) begin
    if (!src_rst) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_frame_done) begin
      if (r_fcnt == c_FC_W'(BLINK_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + c_FC_W'(1);
      end
    end
  end
`endif

  assign busy       = r_busy;
  assign select     = r_sel;
  assign digit_val  = r_digit;
  assign dp         = r_dp;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_display_scan_ctrl                                             |
// | Purpose : Scoreboard bench for display_scan_ctrl (REFRESH_DIV=4). A        |
// |           behavioural model queues expected outputs each clock; they are   |
// |           popped and compared on the falling edge. Directed checks cover   |
// |           commit timing, boundary load, blanking and reset mid-pending.    |
// |           Build with BLINK_EN to exercise blinking (BLINK_FRAMES=2).        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_display_scan_ctrl;

  localparam int RD = 4;
  localparam int BF = 2;

  logic        src_clk = 1'b0;
  logic        src_rst;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic        busy;
  logic [1:0]  select;
  logic [3:0]  digit_val;
  logic        dp;
  logic        blank;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] val;
    logic       dp;
    logic       blank;
    logic       fd;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];

  display_scan_ctrl #(
    .REFRESH_DIV (RD)
`ifdef BLINK_EN
    , .BLINK_FRAMES (BF)
`endif
  ) u_dut (
    .src_clk    (src_clk),
    .src_rst    (src_rst),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
`ifdef BLINK_EN
    .blink_mask (blink_mask),
`endif
    .busy       (busy),
    .select     (select),
    .digit_val  (digit_val),
    .dp         (dp),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 src_clk = ~src_clk;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  int         m_presc, m_sel, m_fcnt;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_adp, m_sdp, m_val;
  logic        m_busy, m_fd, m_dp, m_blank, m_phase;

  // Behavioural model: predicts outputs after each rising edge.
  always @(posedge src_clk) begin : model
    obs_t e;
    logic tick, bnd, old_fd, old_phase;
    if (!src_rst) begin
      m_presc = 0; m_sel = 0; m_fcnt = 0;
      m_act = 0; m_sh = 0; m_adp = 0; m_sdp = 0; m_val = 0;
      m_busy = 0; m_fd = 0; m_dp = 0; m_blank = 0; m_phase = 0;
    end else begin
      old_fd    = m_fd;
      old_phase = m_phase;
      tick      = (m_presc == RD - 1);
      bnd       = tick && (m_sel == 3);
      m_presc   = tick ? 0 : m_presc + 1;
      if (bnd) begin
        if (load) begin
          m_act = value_in; m_adp = dp_in; m_busy = 0;
        end else if (m_busy) begin
          m_act = m_sh; m_adp = m_sdp; m_busy = 0;
        end
      end else if (load) begin
        m_sh = value_in; m_sdp = dp_in; m_busy = 1;
      end
      m_fd = bnd;
      if (tick) begin
        m_sel   = (m_sel + 1) % 4;
        m_val   = 4'(m_act >> (4 * m_sel));
        m_blank = blank_lz && (m_sel != 0) && ((m_act >> (4 * m_sel)) == 16'd0)
                  && ((m_adp >> m_sel) == 4'd0);
`ifdef BLINK_EN
        if (old_phase && blink_mask[m_sel]) m_blank = 1'b1;
`endif
        m_dp = m_adp[m_sel] && !m_blank;
      end
      if (old_fd) begin
        m_fcnt++;
        if (m_fcnt == BF) begin
          m_fcnt  = 0;
          m_phase = ~m_phase;
        end
      end
    end
    e.sel = 2'(m_sel); e.val = m_val; e.dp = m_dp; e.blank = m_blank;
    e.fd = m_fd; e.busy = m_busy;
    exp_q.push_back(e);
  end

  // Scoreboard: compare every cycle on the falling edge.
  always @(negedge src_clk) begin : scoreboard
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_val("scan", 32'({select, digit_val, dp, blank, frame_done, busy}), 32'(e));
    end
  end

  task automatic wait_fd();
    int n = 0;
    @(negedge src_clk);
    while (!frame_done && n < 100) begin
      @(negedge src_clk);
      n++;
    end
    if (!frame_done) chk_val("wait_fd_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_sel(input logic [1:0] s);
    int n = 0;
    @(negedge src_clk);
    while (select != s && n < 100) begin
      @(negedge src_clk);
      n++;
    end
    if (select != s) chk_val("wait_sel_timeout", 32'(select), 32'(s));
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    @(negedge src_clk);
    load     = 1'b0;
  endtask

  initial begin
    int fd_cnt;
    bit seen9;
    src_rst = 1'b0; value_in = 16'd0; dp_in = 4'd0; load = 1'b0;
    blank_lz = 1'b0; blink_mask = 4'd0;
    repeat (3) @(negedge src_clk);
    chk_val("reset_outputs", 32'({select, digit_val, dp, blank, frame_done, busy}), 32'd0);
    src_rst = 1'b1;

    // Scan stepping and frame_done rate
    repeat (3) @(negedge src_clk);
    chk_val("sel_hold", 32'(select), 32'd0);
    @(negedge src_clk);
    chk_val("sel_step", 32'(select), 32'd1);
    fd_cnt = 0;
    repeat (32) begin
      @(negedge src_clk);
      if (frame_done) fd_cnt++;
    end
    chk_val("frame_rate", 32'(fd_cnt), 32'd2);

    // Commit timing: load mid-frame
    wait_sel(2'd1);
    pulse_load(16'h1234, 4'b0100);
    chk_val("busy_pending", 32'(busy), 32'd1);
    wait_fd();
    chk_val("commit_busy", 32'(busy), 32'd0);
    chk_val("commit_d0", 32'(digit_val), 32'h4);
    wait_sel(2'd1); chk_val("commit_d1", 32'(digit_val), 32'h3);
    wait_sel(2'd2); chk_val("commit_d2", 32'({digit_val, dp}), 32'({4'h2, 1'b1}));
    wait_sel(2'd3); chk_val("commit_d3", 32'({digit_val, dp}), 32'({4'h1, 1'b0}));

    // Overwrite before boundary: last write wins
    wait_sel(2'd0);
    pulse_load(16'h1111, 4'd0);
    pulse_load(16'h2222, 4'd0);
    wait_fd();
    chk_val("overwrite", 32'(digit_val), 32'h2);

    // Pending shadow then load on the boundary edge
    wait_fd();
    repeat (5) @(negedge src_clk);
    pulse_load(16'h4444, 4'd0);
    repeat (9) @(negedge src_clk);
    pulse_load(16'h3333, 4'd0);
    chk_val("bnd_load_fd", 32'({frame_done, select}), 32'({1'b1, 2'd0}));
    chk_val("bnd_load_busy", 32'(busy), 32'd0);
    chk_val("bnd_load_d0", 32'(digit_val), 32'h3);
    wait_fd();
    chk_val("bnd_shadow_dropped", 32'(digit_val), 32'h3);

    // Leading-zero blanking
    blank_lz = 1'b1;
    pulse_load(16'h0050, 4'd0);
    wait_fd(); wait_fd();
    chk_val("lz50_s0", 32'(blank), 32'd0);
    wait_sel(2'd1); chk_val("lz50_s1", 32'({digit_val, blank}), 32'({4'h5, 1'b0}));
    wait_sel(2'd2); chk_val("lz50_s2", 32'(blank), 32'd1);
    wait_sel(2'd3); chk_val("lz50_s3", 32'(blank), 32'd1);
    pulse_load(16'h0000, 4'd0);
    wait_fd(); wait_fd();
    chk_val("lz0_s0", 32'(blank), 32'd0);
    wait_sel(2'd1); chk_val("lz0_s1", 32'(blank), 32'd1);
    wait_sel(2'd3); chk_val("lz0_s3", 32'(blank), 32'd1);
    pulse_load(16'h0000, 4'b0100);
    wait_fd(); wait_fd();
    wait_sel(2'd1); chk_val("lzdp_s1", 32'(blank), 32'd0);
    wait_sel(2'd2); chk_val("lzdp_s2", 32'({blank, dp}), 32'({1'b0, 1'b1}));
    wait_sel(2'd3); chk_val("lzdp_s3", 32'(blank), 32'd1);
    blank_lz = 1'b0;

    // Hex nibbles pass through
    pulse_load(16'hFEDC, 4'b1010);
    wait_fd(); wait_fd();
    chk_val("hex_d0", 32'(digit_val), 32'hC);

    // Reset while a value is pending
    wait_fd();
    repeat (3) @(negedge src_clk);
    pulse_load(16'h9999, 4'hF);
    src_rst = 1'b0;
    @(negedge src_clk);
    src_rst = 1'b1;
    chk_val("rst_pending", 32'({busy, digit_val, select}), 32'd0);
    seen9 = 1'b0;
    repeat (48) begin
      @(negedge src_clk);
      if (digit_val == 4'h9) seen9 = 1'b1;
    end
    chk_val("rst_discard", 32'(seen9), 32'd0);

`ifdef BLINK_EN
    // Blinking digit 0; the scoreboard tracks the phase
    blink_mask = 4'b0001;
    pulse_load(16'h1234, 4'b0001);
    repeat (12) wait_fd();
    blink_mask = 4'b0000;
`endif

    repeat (20) @(negedge src_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
